// File: rtl/pll_sup_pkg.sv
// ----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - sup_state_t : supervisor FSM state encoding (PLLRST, WAIT, STABLE, RUN)
//   - DEF_*       : default timing parameters, in clk cycles
//   - CNT_W       : width of the shared state cycle counter
//   - RELOCK_MAX  : saturation value of the relock counter
// ----------------------------------------------------------------------------
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAIT   = 2'd1,
    STABLE = 2'd2,
    RUN    = 2'd3
  } sup_state_t;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65535;

  // Wide enough for the largest programmable interval (65535 cycles).
  localparam int CNT_W = 16;

  localparam logic [7:0] RELOCK_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-stage flip-flop synchronizer for a single asynchronous bit, with a
// synchronous active-high reset that clears every stage.
//
// Ports:
//   clk   : destination clock
//   reset : synchronous active-high reset, clears all stages to 0
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
// ----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int STAGES = 2;

  logic [STAGES-1:0] sync_reg;

  // First stage samples the asynchronous input; it is the only flop allowed
  // to go metastable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= d;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences a PLL out of reset, qualifies its LOCK output, and releases a
// downstream reset only after lock has been stable for a programmed time.
// A lock loss while running re-pulses the PLL; a lock that never arrives
// within the timeout also re-pulses the PLL.
//
// Build option:
//   PLL_SUP_STATUS_EN : when defined, relock_count and timeout_err are live
//                       status registers; when undefined they are tied to 0
//                       and no registers exist for them.
//
// Parameters:
//   PLL_RST_CYCLES      : cycles pll_reset is held per pulse       (2..255)
//   LOCK_STABLE_CYCLES  : consecutive lock cycles before release   (2..65535)
//   LOCK_TIMEOUT_CYCLES : cycles to wait for lock before re-pulse  (2..65535)
//
// Ports:
//   clk          : free-running reference clock (only clock)
//   reset        : synchronous active-high reset
//   pll_lock     : PLL LOCK, asynchronous to clk
//   pll_reset    : PLL RESET, active-high, high only in PLLRST
//   sys_reset    : downstream reset, active-high, low only in RUN
//   ready        : high only in RUN
//   relock_count : saturating count of lock losses seen in RUN
//   timeout_err  : sticky, a lock timeout has occurred
// ----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  // Counter value seen on the last cycle of each timed interval.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             lock_s;
  sup_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pll_reset_reg, sys_reset_reg, ready_reg;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state logic. Priority inside WAIT and STABLE puts the lock_s test
  // first, so a lock arriving on the timeout cycle wins and a lock drop on
  // the final stable count wins.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PLLRST: begin
        if (cnt_reg == RST_LAST) state_next = WAIT;
      end
      WAIT: begin
        if (lock_s)                  state_next = STABLE;
        else if (cnt_reg == TO_LAST) state_next = PLLRST;
      end
      STABLE: begin
        if (!lock_s)                  state_next = WAIT;
        else if (cnt_reg == STB_LAST) state_next = RUN;
      end
      RUN: begin
        if (!lock_s) state_next = PLLRST;
      end
      default: state_next = PLLRST;
    endcase
  end

  // One counter shared by all states, cleared on every transition. RUN has
  // no timed exit, so the counter is parked at 0 there instead of wrapping.
  always_comb begin
    cnt_next = cnt_reg + CNT_ONE;
    if ((state_next != state_reg) || (state_reg == RUN)) begin
      cnt_next = '0;
    end
  end

  // Outputs are loaded from the next-state decode so the output flops change
  // on the same edge as the state register and never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= PLLRST;
      cnt_reg       <= '0;
      pll_reset_reg <= 1'b1;
      sys_reset_reg <= 1'b1;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pll_reset_reg <= (state_next == PLLRST);
      sys_reset_reg <= (state_next != RUN);
      ready_reg     <= (state_next == RUN);
    end
  end

  assign pll_reset = pll_reset_reg;
  assign sys_reset = sys_reset_reg;
  assign ready     = ready_reg;

`ifdef PLL_SUP_STATUS_EN
  logic       timeout_evt, relock_evt;
  logic [7:0] relock_count_reg;
  logic       timeout_err_reg;

  // The only ways back into PLLRST without reset are a WAIT timeout and a
  // RUN lock loss, so the events are decoded from the transition itself.
  assign timeout_evt = (state_reg == WAIT) && (state_next == PLLRST);
  assign relock_evt  = (state_reg == RUN)  && (state_next == PLLRST);

  always_ff @(posedge clk) begin
    if (reset) begin
      relock_count_reg <= '0;
      timeout_err_reg  <= 1'b0;
    end else begin
      if (timeout_evt) timeout_err_reg <= 1'b1;
      if (relock_evt && (relock_count_reg != RELOCK_MAX)) begin
        relock_count_reg <= relock_count_reg + 8'd1;
      end
    end
  end

  assign relock_count = relock_count_reg;
  assign timeout_err  = timeout_err_reg;
`else
  assign relock_count = 8'd0;
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with PLL_RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=20. Expected values are pushed
// to a scoreboard queue and popped when the matching DUT observation is
// taken. Status expectations follow PLL_SUP_STATUS_EN.
// ----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int P_RST = 4;
  localparam int P_STB = 8;
  localparam int P_TO  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic [7:0] relock_count;
  logic       timeout_err;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_STABLE_CYCLES  (P_STB),
    .LOCK_TIMEOUT_CYCLES (P_TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Status outputs are only live when the feature is built in.
  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef PLL_SUP_STATUS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0d expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
      $display("check %-22s observed=%0d expected=%0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic pr, input logic sr,
                               input logic rdy, input logic [7:0] rc, input logic te);
    push({tag, ".pll_reset"}, {31'd0, pr});
    push({tag, ".sys_reset"}, {31'd0, sr});
    push({tag, ".ready"},     {31'd0, rdy});
    push({tag, ".relock"},    {24'd0, rc});
    push({tag, ".timeout"},   {31'd0, te});
    pop_check({31'd0, pll_reset});
    pop_check({31'd0, sys_reset});
    pop_check({31'd0, ready});
    pop_check({24'd0, relock_count});
    pop_check({31'd0, timeout_err});
  endtask

  // Drop lock while in RUN, count cycles until ready falls, restore lock and
  // wait (bounded) for ready to return.
  task automatic drop_relock(output int fall_n, output int rise_n);
    int k;
    pll_lock = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ready === 1'b1 && k < 50);
    fall_n = k;
    pll_lock = 1'b1;
    k = 0;
    while (ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    rise_n = k;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, n1, n2, fall_n, rise_n;
    logic [7:0] rc_exp;

    // Reset state.
    reset = 1'b1;
    pll_lock = 1'b1;
    cyc(3);
    check_outputs("reset", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // Clean acquisition with lock tied high.
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pll_reset === 1'b1 && n < 100);
    push("pll_reset_len", P_RST);
    pop_check(32'(n));
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    push("ready_rise_12to16", 32'd1);
    pop_check({31'd0, (n >= 12 && n <= 16)});
    check_outputs("run", 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);

    // One-cycle lock glitch during STABLE: STABLE entered 5 cycles after
    // release; the glitch reaches lock_s at cycle 9, WAIT re-qualifies at 10,
    // then 8 fresh stable cycles give RUN at cycle 18.
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(6);
    pll_lock = 1'b0;
    cyc(1);
    pll_lock = 1'b1;
    n = 7;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    push("glitch_ready_rise", 32'd18);
    pop_check(32'(n));
    push("glitch_relock", st(0));
    pop_check({24'd0, relock_count});

    // Three lock losses in RUN.
    for (int i = 0; i < 3; i++) begin
      drop_relock(fall_n, rise_n);
      push("ready_fall_le3", 32'd1);
      pop_check({31'd0, (fall_n >= 1 && fall_n <= 3)});
      push("relock_ready_back", 32'd1);
      pop_check({31'd0, (rise_n < 200)});
    end
    push("relock_count_3", st(3));
    pop_check({24'd0, relock_count});

    for (int i = 0; i < 2; i++) drop_relock(fall_n, rise_n);
    push("relock_count_5", st(5));
    pop_check({24'd0, relock_count});

    // One-cycle reset while in RUN.
    reset = 1'b1;
    cyc(1);
    check_outputs("midrun_reset", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // Lock never arrives: PLL re-pulsed every 4 + 20 = 24 cycles.
    pll_lock = 1'b0;
    cyc(1);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pll_reset === 1'b1 && n < 100);
    push("to_first_pulse_len", P_RST);
    pop_check(32'(n));
    push("to_before_timeout", 32'd0);
    pop_check({31'd0, timeout_err});
    while (pll_reset !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n1 = n;
    push("to_first_repulse", 32'd24);
    pop_check(32'(n1));
    push("to_err_set", st(1));
    pop_check({31'd0, timeout_err});
    while (pll_reset === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    while (pll_reset !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n2 = n;
    push("to_repulse_period", 32'd24);
    pop_check(32'(n2 - n1));
    push("to_err_sticky", st(1));
    pop_check({31'd0, timeout_err});
    check_outputs("to_state", 1'b1, 1'b1, 1'b0, st(1) != 0 ? 8'd0 : 8'd0, st(1) != 0);

    // Saturation: 300 lock losses.
    reset = 1'b1;
    pll_lock = 1'b1;
    cyc(2);
    reset = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 300; i++) drop_relock(fall_n, rise_n);
    rc_exp = st(255) != 0 ? 8'd255 : 8'd0;
    check_outputs("saturate", 1'b0, 1'b0, 1'b1, rc_exp, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
